// File: rtl/cu_sequencer.sv
// Accumulator CPU instruction sequencer: 22-state one-hot strobe FSM with
// conditional branch, wait timeouts, sticky fault, single-step and icount.
module cu_sequencer #(
  parameter int OP_W  = 6,
  parameter int TO_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             ra,
  input  logic [1:0]       cond,
  input  logic [2:0]       flags,
  input  logic             ack_alu,
  input  logic             inp_ack,
  input  logic             out_ack,
  input  logic             step_mode,
  input  logic             step_go,
  input  logic [TO_W-1:0]  timeout_lim,
  output logic [21:0]      c,
  output logic             finish,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_START    = 5'd1,
    S_FETCH    = 5'd2,
    S_DECODE   = 5'd3,
    S_LD_IMM   = 5'd4,
    S_WB       = 5'd5,
    S_ADDR     = 5'd6,
    S_ALU_WAIT = 5'd7,
    S_MEM_RD   = 5'd8,
    S_MEM_WR   = 5'd9,
    S_PSH1     = 5'd10,
    S_PSH2     = 5'd11,
    S_PSH3     = 5'd12,
    S_POP1     = 5'd13,
    S_POP2     = 5'd14,
    S_POP3     = 5'd15,
    S_IN_WAIT  = 5'd16,
    S_IN_LATCH = 5'd17,
    S_OUT_WAIT = 5'd18,
    S_BR_TAKE  = 5'd19,
    S_STEP     = 5'd20,
    S_FAULT    = 5'd21
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wcnt_q, wcnt_d;
  logic [1:0]       fcode_q, fcode_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             is_st_q, is_st_d;

  logic             illegal_hi;
  logic [5:0]       op_lo;
  logic             cond_true;
  logic             retire;
  logic [TO_W-1:0]  wnext;
  logic             expired;
  logic             unused_ra;

  // ra steers the datapath register mux, not the sequence itself
  assign unused_ra  = ra;
  assign illegal_hi = |(op >> 6);
  assign op_lo      = op[5:0];
  assign wnext      = wcnt_q + 1'b1;
  assign expired    = (timeout_lim != '0) && (wnext == timeout_lim);

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      2'b01:   cond_true = flags[0];
      2'b10:   cond_true = flags[1];
      2'b11:   cond_true = flags[2];
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = '0;
    fcode_d  = fcode_q;
    icount_d = icount_q;
    is_st_d  = is_st_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_START;
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        is_st_d = (op_lo == 6'd3);
        if (illegal_hi) begin
          state_d = S_FAULT;
          fcode_d = 2'b01;
        end else begin
          case (op_lo)
            6'd0: begin
              state_d = S_IDLE;
              retire  = 1'b1;
            end
            6'd1:    state_d = S_LD_IMM;
            6'd2:    state_d = S_ADDR;
            6'd3:    state_d = S_ADDR;
            6'd4:    state_d = S_PSH1;
            6'd5:    state_d = S_POP1;
            6'd6:    state_d = S_IN_WAIT;
            6'd7:    state_d = S_OUT_WAIT;
            6'd8: begin
              if (cond_true) state_d = S_BR_TAKE;
              else           retire  = 1'b1;
            end
            default: begin
              state_d = S_FAULT;
              fcode_d = 2'b01;
            end
          endcase
        end
      end
      S_LD_IMM: state_d = S_WB;
      S_ADDR:   state_d = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (ack_alu) begin
          state_d = is_st_q ? S_MEM_WR : S_MEM_RD;
        end else if (expired) begin
          state_d = S_FAULT;
          fcode_d = 2'b10;
        end else begin
          wcnt_d = wnext;
        end
      end
      S_MEM_RD: state_d = S_WB;
      S_PSH1:   state_d = S_PSH2;
      S_PSH2:   state_d = S_PSH3;
      S_POP1:   state_d = S_POP2;
      S_POP2:   state_d = S_POP3;
      S_IN_WAIT: begin
        if (inp_ack) begin
          state_d = S_IN_LATCH;
        end else if (expired) begin
          state_d = S_FAULT;
          fcode_d = 2'b11;
        end else begin
          wcnt_d = wnext;
        end
      end
      S_OUT_WAIT: begin
        if (out_ack) begin
          retire = 1'b1;
        end else if (expired) begin
          state_d = S_FAULT;
          fcode_d = 2'b11;
        end else begin
          wcnt_d = wnext;
        end
      end
      S_WB, S_MEM_WR, S_PSH3, S_POP3,
      S_IN_LATCH, S_BR_TAKE: retire = 1'b1;
      S_STEP:   if (step_go) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    // HLT already chose IDLE; everything else continues or pauses
    if (retire) begin
      icount_d = icount_q + 1'b1;
      if (state_d != S_IDLE) state_d = step_mode ? S_STEP : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      fcode_q  <= 2'b00;
      icount_q <= '0;
      is_st_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      fcode_q  <= fcode_d;
      icount_q <= icount_d;
      is_st_q  <= is_st_d;
    end
  end

  assign c          = 22'd1 << state_q;
  assign finish     = (state_q == S_IDLE);
  assign fault      = (state_q == S_FAULT);
  assign busy       = !finish && !fault;
  assign fault_code = fcode_q;
  assign icount     = icount_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer: walks each opcode path,
// wait/timeout boundaries, single-step and reset behaviour.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, ra;
  logic [5:0]  op;
  logic [1:0]  cond;
  logic [2:0]  flags;
  logic        ack_alu, inp_ack, out_ack;
  logic        step_mode, step_go;
  logic [7:0]  timeout_lim;
  logic [21:0] c;
  logic        finish, busy, fault;
  logic [1:0]  fault_code;
  logic [15:0] icount;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cu_sequencer #(.OP_W(6), .TO_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra),
    .cond(cond), .flags(flags), .ack_alu(ack_alu),
    .inp_ack(inp_ack), .out_ack(out_ack),
    .step_mode(step_mode), .step_go(step_go),
    .timeout_lim(timeout_lim), .c(c), .finish(finish),
    .busy(busy), .fault(fault), .fault_code(fault_code),
    .icount(icount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (c !== 22'h000001) begin
      n_fail++; $display("FAIL reset_c got %h exp %h", c, 22'h1);
    end
    n_chk++;
    if (finish !== 1'b1 || busy !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got f=%b b=%b flt=%b exp 1 0 0",
               finish, busy, fault);
    end
    n_chk++;
    if (fault_code !== 2'b00 || icount !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs got code=%b ic=%0d exp 00 0",
               fault_code, icount);
    end
  endtask

  task automatic test_ldi();
    int exp_s [6] = '{1, 2, 3, 4, 5, 2};
    op = 6'd1; ra = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL ldi_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
    end
    n_chk++;
    if (icount !== 16'd1 || busy !== 1'b1 || finish !== 1'b0) begin
      n_fail++;
      $display("FAIL ldi_retire got ic=%0d b=%b f=%b exp 1 1 0",
               icount, busy, finish);
    end
  endtask

  task automatic test_ld();
    int exp_s [8] = '{3, 6, 7, 7, 7, 8, 5, 2};
    op = 6'd2; timeout_lim = 8'd8;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL ld_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
      ack_alu = (i == 4);
    end
    n_chk++;
    if (icount !== 16'd2 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_retire got ic=%0d flt=%b exp 2 0", icount, fault);
    end
  endtask

  task automatic test_st_ack_wins();
    int exp_s [6] = '{3, 6, 7, 7, 9, 2};
    op = 6'd3; timeout_lim = 8'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL st_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
      ack_alu = (i == 3);
    end
    n_chk++;
    if (icount !== 16'd3 || fault_code !== 2'b00) begin
      n_fail++;
      $display("FAIL st_retire got ic=%0d code=%b exp 3 00",
               icount, fault_code);
    end
  endtask

  task automatic test_branch();
    int exp_s [10] = '{3, 2, 3, 19, 2, 3, 2, 3, 19, 2};
    op = 6'd8; cond = 2'b01; flags = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL br_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
      if (i == 1) flags = 3'b001;
      if (i == 4) cond  = 2'b10;
      if (i == 6) cond  = 2'b00;
    end
    n_chk++;
    if (icount !== 16'd7) begin
      n_fail++; $display("FAIL br_icount got %0d exp 7", icount);
    end
  endtask

  task automatic test_pop_out();
    int exp_p [5] = '{3, 13, 14, 15, 2};
    int exp_o [4] = '{3, 18, 18, 2};
    op = 6'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_p[i])) begin
        n_fail++;
        $display("FAIL pop_state[%0d] got %h exp %h", i, c, 22'd1 << exp_p[i]);
      end
    end
    op = 6'd7; timeout_lim = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_o[i])) begin
        n_fail++;
        $display("FAIL out_state[%0d] got %h exp %h", i, c, 22'd1 << exp_o[i]);
      end
      out_ack = (i == 2);
    end
    n_chk++;
    if (icount !== 16'd9) begin
      n_fail++; $display("FAIL out_icount got %0d exp 9", icount);
    end
  endtask

  task automatic test_in_no_timeout();
    op = 6'd6; timeout_lim = 8'd0;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++;
      if (c !== 22'h010000) begin
        n_fail++; $display("FAIL in_wait[%0d] got %h exp %h", i, c, 22'h010000);
      end
    end
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    n_chk++;
    if (c !== 22'h020000) begin
      n_fail++; $display("FAIL in_latch got %h exp %h", c, 22'h020000);
    end
    tick();
    n_chk++;
    if (c !== 22'h000004 || icount !== 16'd10) begin
      n_fail++;
      $display("FAIL in_retire got c=%h ic=%0d exp 000004 10", c, icount);
    end
  endtask

  task automatic test_step();
    int exp_s [5] = '{3, 10, 11, 12, 20};
    step_mode = 1'b1; op = 6'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL psh_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
    end
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (c !== 22'h100000) begin
        n_fail++; $display("FAIL step_hold[%0d] got %h exp %h", i, c, 22'h100000);
      end
    end
    start = 1'b0; step_go = 1'b1;
    tick();
    step_go = 1'b0;
    n_chk++;
    if (c !== 22'h000004 || icount !== 16'd11) begin
      n_fail++;
      $display("FAIL step_go got c=%h ic=%0d exp 000004 11", c, icount);
    end
    op = 6'd0;
    tick();
    tick();
    n_chk++;
    if (c !== 22'h000001 || finish !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt got c=%h f=%b b=%b exp 000001 1 0", c, finish, busy);
    end
    n_chk++;
    if (icount !== 16'd12) begin
      n_fail++; $display("FAIL hlt_icount got %0d exp 12", icount);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_in_timeout();
    int exp_s [8] = '{1, 2, 3, 16, 16, 16, 16, 21};
    op = 6'd6; timeout_lim = 8'd4; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL into_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
    end
    n_chk++;
    if (fault_code !== 2'b11 || busy !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL into_fault got code=%b b=%b flt=%b exp 11 0 1",
               fault_code, busy, fault);
    end
    start = 1'b1; step_go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (c !== 22'h200000 || icount !== 16'd12) begin
        n_fail++;
        $display("FAIL fault_sticky[%0d] got c=%h ic=%0d exp 200000 12",
                 i, c, icount);
      end
    end
    start = 1'b0; step_go = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (c !== 22'h000001 || fault_code !== 2'b00 || icount !== 16'd0) begin
      n_fail++;
      $display("FAIL fault_rst got c=%h code=%b ic=%0d exp 000001 00 0",
               c, fault_code, icount);
    end
  endtask

  task automatic test_illegal();
    int exp_s [4] = '{1, 2, 3, 21};
    op = 6'h3F; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL ill_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
    end
    n_chk++;
    if (fault_code !== 2'b01 || icount !== 16'd0) begin
      n_fail++;
      $display("FAIL ill_code got code=%b ic=%0d exp 01 0", fault_code, icount);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_alu_timeout();
    int exp_s [8] = '{1, 2, 3, 6, 7, 7, 7, 21};
    op = 6'd2; timeout_lim = 8'd3; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (c !== (22'd1 << exp_s[i])) begin
        n_fail++;
        $display("FAIL aluto_state[%0d] got %h exp %h", i, c, 22'd1 << exp_s[i]);
      end
    end
    n_chk++;
    if (fault_code !== 2'b10) begin
      n_fail++; $display("FAIL aluto_code got %b exp 10", fault_code);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_rst_mid();
    op = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_chk++;
    if (c !== 22'h000008) begin
      n_fail++; $display("FAIL mid_pre got %h exp %h", c, 22'h000008);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (c !== 22'h000001 || finish !== 1'b1 || busy !== 1'b0 ||
        icount !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_rst got c=%h f=%b b=%b ic=%0d exp 000001 1 0 0",
               c, finish, busy, icount);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ra = 1'b0; op = '0;
    cond = 2'b00; flags = 3'b000;
    ack_alu = 1'b0; inp_ack = 1'b0; out_ack = 1'b0;
    step_mode = 1'b0; step_go = 1'b0; timeout_lim = 8'd0;
    test_reset();
    test_ldi();
    test_ld();
    test_st_ack_wins();
    test_branch();
    test_pop_out();
    test_in_no_timeout();
    test_step();
    test_in_timeout();
    test_illegal();
    test_alu_timeout();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
